// File: rtl/serial_fifo_ctrl.sv
// Buffered COM controller: RX/TX byte FIFOs, a status/control register and a
// maskable COM interrupt between the UART pair and the device COM window.

module sfc_fifo #(
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [7:0]   wdata_i,
  output logic [7:0]   head_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [7:0]    mem_q [0:(1<<AW)-1];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  // Caller only pushes when not full (or popping) and only pops when not empty.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = cnt_q[AW];

endmodule

module serial_fifo_ctrl #(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        readEnable_i,
  input  logic        mode_i,
  input  logic [31:0] dataSave_i,
  output logic [31:0] dataLoad_o,
  output logic        int_o,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  logic       rx_rd, st_rd, tx_wr, ct_wr;
  logic       rx_push, rx_pop, rx_drop, rx_empty, rx_full;
  logic       tx_push, tx_pop, tx_empty, tx_full, tx_start;
  logic [7:0] rx_head, tx_head;

  logic [1:0] state_q, state_d;
  logic       wb_cnt_q, wb_cnt_d;
  logic       overrun_q, overrun_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       rx_ie_q, rx_ie_d;
  logic       tx_ie_q, tx_ie_d;
  logic       int_q, int_d;
  logic       start_q, start_d;
  logic [7:0] txd_q, txd_d;
  logic       unused_hi;

  assign unused_hi = ^dataSave_i[31:8];

  assign rx_rd = enable_i &  readEnable_i & ~mode_i;
  assign st_rd = enable_i &  readEnable_i &  mode_i;
  assign tx_wr = enable_i & ~readEnable_i & ~mode_i;
  assign ct_wr = enable_i & ~readEnable_i &  mode_i;

  // A pop frees the slot a same-cycle push into a full RX FIFO needs.
  assign rx_pop  = rx_rd & ~rx_empty;
  assign rx_push = rxdReady_i & (~rx_full | rx_pop);
  assign rx_drop = rxdReady_i & rx_full & ~rx_pop;

  assign tx_push  = tx_wr & ~tx_full;
  assign tx_start = (state_q == ST_IDLE) & ~tx_empty & ~txdBusy_i;
  assign tx_pop   = tx_start;

  sfc_fifo #(.AW(RX_DEPTH_LOG2)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (rxdData_i),
    .head_o  (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  sfc_fifo #(.AW(TX_DEPTH_LOG2)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (dataSave_i[7:0]),
    .head_o  (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  // Status clear and a new overrun in the same cycle: the new event wins.
  always_comb begin
    overrun_d  = overrun_q;
    drop_cnt_d = drop_cnt_q;
    tx_ovf_d   = tx_ovf_q;
    rx_ie_d    = rx_ie_q;
    tx_ie_d    = tx_ie_q;
    if (st_rd) begin
      overrun_d  = 1'b0;
      drop_cnt_d = 8'h00;
      tx_ovf_d   = 1'b0;
    end
    if (rx_drop) begin
      overrun_d = 1'b1;
      if (st_rd)                    drop_cnt_d = 8'h01;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'h01;
    end
    if (tx_wr & tx_full) tx_ovf_d = 1'b1;
    if (ct_wr) begin
      rx_ie_d = dataSave_i[0];
      tx_ie_d = dataSave_i[1];
    end
  end

  // WAIT_BUSY gives up after two quiet cycles in case busy was never seen.
  always_comb begin
    state_d  = state_q;
    wb_cnt_d = wb_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d  = ST_WAIT_BUSY;
          wb_cnt_d = 1'b0;
        end
      end
      ST_WAIT_BUSY: begin
        if (txdBusy_i)     state_d  = ST_WAIT_DONE;
        else if (wb_cnt_q) state_d  = ST_IDLE;
        else               wb_cnt_d = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (!txdBusy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign start_d = tx_start;
  assign txd_d   = tx_start ? tx_head : txd_q;
  assign int_d   = (rx_ie_q & ~rx_empty)
                 | (tx_ie_q & tx_empty & (state_q == ST_IDLE) & ~txdBusy_i)
                 | overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wb_cnt_q   <= 1'b0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= 8'h00;
      tx_ovf_q   <= 1'b0;
      rx_ie_q    <= 1'b1;
      tx_ie_q    <= 1'b0;
      int_q      <= 1'b0;
      start_q    <= 1'b0;
      txd_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      wb_cnt_q   <= wb_cnt_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ie_q    <= rx_ie_d;
      tx_ie_q    <= tx_ie_d;
      int_q      <= int_d;
      start_q    <= start_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    dataLoad_o = 32'h0;
    if (rx_rd && !rx_empty)
      dataLoad_o = {24'h0, rx_head};
    else if (st_rd)
      dataLoad_o = {16'h0, drop_cnt_q, 2'b00, tx_ovf_q, overrun_q,
                    tx_ie_q, rx_ie_q, ~rx_empty, ~tx_full};
  end

  assign int_o      = int_q;
  assign txdStart_o = start_q;
  assign txdData_o  = txd_q;

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// Scoreboard bench for serial_fifo_ctrl: queue-based reference model, bench
// transmitter, and a negedge monitor that checks reads and TX start pulses.

module tb_serial_fifo_ctrl;

  localparam int RXD = 16;
  localparam int TXD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0, readEnable_i = 1'b0, mode_i = 1'b0;
  logic [31:0] dataSave_i = '0;
  logic [31:0] dataLoad_o;
  logic        int_o;
  logic        rxdReady_i = 1'b0;
  logic [7:0]  rxdData_i = '0;
  logic        txdBusy_i = 1'b0;
  logic        txdStart_o;
  logic [7:0]  txdData_o;

  serial_fifo_ctrl #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .readEnable_i(readEnable_i),
    .mode_i(mode_i), .dataSave_i(dataSave_i), .dataLoad_o(dataLoad_o),
    .int_o(int_o), .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i),
    .txdBusy_i(txdBusy_i), .txdStart_o(txdStart_o), .txdData_o(txdData_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [31:0] expq[$];
  logic        m_ovr, m_txovf, m_rxie, m_txie;
  logic [7:0]  m_drop;

  int n_chk = 0, n_pass = 0;
  int n_starts = 0, cyc = 0, last_start = 0;
  bit have_last = 0;
  int tx_force = 0;   // 0 = transmitter model, 1 = hold busy high
  int tx_len = 10;    // busy length per byte, 0 = random
  int busy_cnt = 0;
  bit pend = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  function automatic logic [31:0] m_stat();
    return {16'h0, m_drop, 2'b00, m_txovf, m_ovr, m_txie, m_rxie,
            rxq.size() != 0, txq.size() < TXD};
  endfunction

  // Bench transmitter: busy rises the cycle after a start and holds for tx_len cycles.
  always begin
    @(posedge clk); #1;
    if (tx_force == 1) txdBusy_i = 1'b1;
    else begin
      if (pend) begin
        busy_cnt = (tx_len != 0) ? tx_len : int'($urandom_range(3, 12));
        pend = 0;
      end
      txdBusy_i = (busy_cnt != 0);
      if (busy_cnt != 0) busy_cnt--;
    end
    if (txdStart_o) pend = 1;
  end

  // Monitor
  logic [31:0] e32;
  logic [7:0]  e8;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (enable_i && readEnable_i) begin
        if (expq.size() == 0) begin
          n_chk++; $display("FAIL rd_underflow: read seen, no expected value queued");
        end else begin
          e32 = expq.pop_front();
          chk(mode_i ? "status_rd" : "data_rd", dataLoad_o, e32);
        end
      end else if (!enable_i) chk("idle_load", dataLoad_o, 32'h0);
      if (txdStart_o) begin
        n_starts++;
        chk("start_busy", {31'h0, txdBusy_i}, 32'h0);
        if (have_last) chk("start_spacing", {31'h0, (cyc - last_start) >= 3}, 32'h1);
        have_last = 1; last_start = cyc;
        if (txq.size() == 0) begin
          n_chk++; $display("FAIL tx_unexpected: start with data %h, expected none", txdData_o);
        end else begin
          e8 = txq.pop_front();
          chk("tx_data", {24'h0, txdData_o}, {24'h0, e8});
        end
      end
    end
  end

  // One access cycle; model is advanced to the state after the edge.
  task automatic acc(input logic en, input logic rd, input logic md, input logic [31:0] wd,
                     input logic rv, input logic [7:0] rb);
    logic [7:0] t;
    enable_i = en; readEnable_i = rd; mode_i = md; dataSave_i = wd;
    rxdReady_i = rv; rxdData_i = rb;
    if (en && rd) expq.push_back(md ? m_stat() : (rxq.size() != 0 ? {24'h0, rxq[0]} : 32'h0));
    if (en && rd && !md && rxq.size() != 0) t = rxq.pop_front();
    if (en && rd && md) begin m_ovr = 0; m_txovf = 0; m_drop = 0; end
    if (rv) begin
      if (rxq.size() < RXD) rxq.push_back(rb);
      else begin m_ovr = 1; if (m_drop != 8'hFF) m_drop++; end
    end
    if (en && !rd && !md) begin
      if (txq.size() < TXD) txq.push_back(wd[7:0]); else m_txovf = 1;
    end
    if (en && !rd && md) begin m_rxie = wd[0]; m_txie = wd[1]; end
    @(posedge clk); #1;
    enable_i = 0; readEnable_i = 0; mode_i = 0; dataSave_i = 0; rxdReady_i = 0; rxdData_i = 0;
  endtask

  task automatic rx(input logic [7:0] b);      acc(0, 0, 0, 0, 1, b);               endtask
  task automatic rd_data();                    acc(1, 1, 0, 0, 0, 0);               endtask
  task automatic rd_stat();                    acc(1, 1, 1, 0, 0, 0);               endtask
  task automatic wr_data(input logic [7:0] b); acc(1, 0, 0, {24'h0, b}, 0, 0);      endtask
  task automatic wr_ctl(input logic [1:0] v);  acc(1, 0, 1, {30'h0, v}, 0, 0);      endtask
  task automatic idle(input int n);            repeat (n) begin @(posedge clk); #1; end endtask

  task automatic do_reset();
    rst = 1; enable_i = 0; readEnable_i = 0; mode_i = 0; dataSave_i = 0;
    rxdReady_i = 0; rxdData_i = 0;
    idle(2);
    rst = 0;
    rxq.delete(); txq.delete(); expq.delete();
    m_ovr = 0; m_txovf = 0; m_drop = 0; m_rxie = 1; m_txie = 0;
  endtask

  task automatic wait_tx_drain(input string nm, input int maxc);
    int k = 0;
    while ((txq.size() != 0 || txdBusy_i) && k < maxc) begin idle(1); k++; end
    if (k >= maxc) begin n_chk++; $display("FAIL %s: drain timeout, %0d bytes left, expected 0", nm, txq.size()); end
    idle(15);
  endtask

  initial begin
    int s0, k, n, op;
    logic [7:0] b;
    do_reset();
    idle(1);
    // Reset state
    chk("rst_start", {31'h0, txdStart_o}, 32'h0);
    chk("rst_txdata", {24'h0, txdData_o}, 32'h0);
    chk("rst_int", {31'h0, int_o}, 32'h0);
    rd_stat();

    // RX order and empty read
    rx(8'h41); rx(8'h42); rx(8'h43);
    rd_data(); rd_data(); rd_stat(); rd_data(); rd_stat(); rd_data();

    // Overrun, clear-on-read, then saturation of the drop counter
    for (int i = 0; i < 18; i++) rx(8'h60 + 8'(i));
    rd_stat(); rd_stat();
    for (int i = 0; i < 16; i++) rd_data();
    for (int i = 0; i < 16 + 270; i++) rx(8'(i * 7));
    rd_stat();
    acc(1, 1, 1, 0, 1, 8'h5A);   // clear and new drop in the same cycle
    rd_stat();
    for (int i = 0; i < 16; i++) rd_data();

    // Interrupt
    do_reset();
    rx(8'h11);
    chk("int_lat0", {31'h0, int_o}, 32'h0);
    idle(1);
    chk("int_rx", {31'h0, int_o}, 32'h1);
    rd_data();
    chk("int_pop0", {31'h0, int_o}, 32'h1);
    idle(1);
    chk("int_pop1", {31'h0, int_o}, 32'h0);
    wr_ctl(2'b10);
    idle(1);
    chk("int_txie", {31'h0, int_o}, 32'h1);
    wr_ctl(2'b00);
    idle(1);
    chk("int_off", {31'h0, int_o}, 32'h0);
    wr_ctl(2'b01);

    // TX drain with 10-cycle busy
    tx_len = 10; s0 = n_starts;
    wr_data(8'h55); wr_data(8'hAA);
    wait_tx_drain("tx_drain", 200);
    chk("tx_two_starts", n_starts - s0, 32'd2);

    // TX full with busy held high
    tx_force = 1; idle(2);
    s0 = n_starts;
    for (int i = 0; i < 16; i++) wr_data(8'h80 + 8'(i));
    rd_stat();
    wr_data(8'hFE);
    rd_stat();
    tx_force = 0; tx_len = 3;
    wait_tx_drain("tx_full_drain", 400);
    idle(20);
    chk("tx_full_starts", n_starts - s0, 32'd16);

    // Full RX simultaneous push+pop
    for (int i = 0; i < 16; i++) rx(8'hC0 + 8'(i));
    acc(1, 1, 0, 0, 1, 8'hEE);
    rd_stat();
    for (int i = 0; i < 16; i++) rd_data();
    rd_data();

    // Randomised traffic
    tx_len = 0;
    for (int i = 0; i < 600; i++) begin
      op = $urandom_range(0, 9);
      b  = 8'($urandom);
      k  = (i < 300) ? ($urandom_range(0, 1) == 0 ? 1 : 0) : ($urandom_range(0, 3) == 0 ? 1 : 0);
      if (op <= 2)                           acc(1, 1, 0, 0, k[0], b);
      else if (op == 3)                      acc(1, 1, 1, 0, k[0], b);
      else if (op <= 5 && txq.size() < 14)   acc(1, 0, 0, $urandom, k[0], b);
      else if (op == 6)                      acc(1, 0, 1, $urandom, k[0], b);
      else                                   acc(0, 0, 0, 0, k[0], b);
    end
    wait_tx_drain("rand_drain", 600);
    rd_stat();
    n = rxq.size();
    for (int i = 0; i <= n; i++) rd_data();

    // Reset while the transmitter is busy
    tx_len = 10; wr_ctl(2'b01);
    wr_data(8'h77);
    k = 0;
    while (!txdBusy_i && k < 20) begin idle(1); k++; end
    if (k >= 20) begin n_chk++; $display("FAIL busy_wait: busy stayed %b, expected 1", txdBusy_i); end
    s0 = n_starts;
    wr_data(8'h88);
    do_reset();
    rd_stat();
    chk("rst_mid_start", {31'h0, txdStart_o}, 32'h0);
    wr_data(8'h99);
    wait_tx_drain("rst_drain", 100);
    chk("rst_mid_starts", n_starts - s0, 32'd1);

    idle(3);
    chk("sb_empty", expq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
